// File: rtl/button_event_arbiter.sv
// ---------------------------------------------------------------------------
// button_event_arbiter
//
// Shares one downstream event consumer between N_BTN button channels.
// Single-cycle press pulses are latched as pending, offered one at a time in
// round-robin order over a valid/ready handshake, and a fixed hold-off gap is
// enforced after every accepted event. Presses arriving on a channel that is
// already pending are counted (saturating) as dropped.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous reset, active low
//   bp        per-channel press pulses (one cycle per press)
//   ev_valid  event offered to the consumer
//   ev_idx    channel index of the offered event
//   ev_ready  consumer accepts when ev_valid && ev_ready at a clock edge
//   pending   latched, not-yet-accepted presses
//   drop_cnt  saturating count of dropped presses
//   busy      high while offering an event or serving the hold-off gap
// ---------------------------------------------------------------------------
module button_event_arbiter #(
  parameter int N_BTN   = 4,
  parameter int IDX_W   = 2,
  parameter int HOLDOFF = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] bp,
  output logic             ev_valid,
  output logic [IDX_W-1:0] ev_idx,
  input  logic             ev_ready,
  output logic [N_BTN-1:0] pending,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Hold-off counter only has to represent 0..HOLDOFF.
  localparam int HCNT_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  // Wide enough to add every channel's drop to a full counter without wrap.
  localparam int SUM_W  = CNT_W + $clog2(N_BTN + 1);
  localparam logic [SUM_W-1:0] DROP_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  state_t            state_reg, state_next;
  logic [N_BTN-1:0]  pending_reg, pending_next;
  logic              ev_valid_reg;
  logic [IDX_W-1:0]  ev_idx_reg;
  logic [IDX_W-1:0]  ptr_reg, ptr_next;
  logic [HCNT_W-1:0] hold_cnt_reg;
  logic [CNT_W-1:0]  drop_cnt_reg, drop_cnt_next;

  logic              accept;
  logic [N_BTN-1:0]  acc_ch;
  logic [N_BTN-1:0]  drop_ch;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  scan_idx;
  logic [SUM_W-1:0]  drop_sum;

  // A handshake only happens while an event is actually on offer.
  assign accept = (state_reg == OFFER) && ev_valid_reg && ev_ready;

  // -------------------------------------------------------------------------
  // Per-channel pending latch. A press on the edge its own channel is
  // accepted re-arms the latch as a fresh press instead of counting a drop.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
    assign acc_ch[gi]       = accept && (ev_idx_reg == IDX_W'(gi));
    assign pending_next[gi] = bp[gi] | (pending_reg[gi] & ~acc_ch[gi]);
    assign drop_ch[gi]      = bp[gi] & pending_reg[gi] & ~acc_ch[gi];
  end

  // Several channels may drop on the same edge; add them all, then saturate.
  always_comb begin
    drop_sum = {{(SUM_W-CNT_W){1'b0}}, drop_cnt_reg};
    for (int i = 0; i < N_BTN; i++) begin
      drop_sum = drop_sum + SUM_W'(drop_ch[i]);
    end
    if (drop_sum > DROP_MAX) begin
      drop_cnt_next = {CNT_W{1'b1}};
    end else begin
      drop_cnt_next = drop_sum[CNT_W-1:0];
    end
  end

  // -------------------------------------------------------------------------
  // Round-robin pick: first pending channel at or after ptr, wrapping.
  // Uses the latched pending vector, so a press needs one edge to latch and
  // one more to be offered.
  // -------------------------------------------------------------------------
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < N_BTN; k++) begin
      scan_idx = IDX_W'((int'(ptr_reg) + k) % N_BTN);
      if (!sel_found && pending_reg[scan_idx]) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx;
      end
    end
  end

  // Pointer moves just past the channel that was served.
  always_comb begin
    if (ev_idx_reg == IDX_W'(N_BTN - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = ev_idx_reg + IDX_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (sel_found) begin
          state_next = OFFER;
        end
      end
      OFFER: begin
        if (accept) begin
          state_next = (HOLDOFF == 0) ? IDLE : HOLD;
        end
      end
      HOLD: begin
        // Counter was loaded with HOLDOFF on accept; leaving on 1 makes the
        // gap exactly HOLDOFF cycles long.
        if (hold_cnt_reg == HCNT_W'(1)) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output logic
  // -------------------------------------------------------------------------
  always_comb begin
    busy = (state_reg != IDLE);
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_reg  <= '0;
      drop_cnt_reg <= '0;
      ev_valid_reg <= 1'b0;
      ev_idx_reg   <= '0;
      ptr_reg      <= '0;
      hold_cnt_reg <= '0;
    end else begin
      pending_reg  <= pending_next;
      drop_cnt_reg <= drop_cnt_next;
      if (state_reg == IDLE && sel_found) begin
        ev_valid_reg <= 1'b1;
        ev_idx_reg   <= sel_idx;
      end else if (accept) begin
        ev_valid_reg <= 1'b0;
        ptr_reg      <= ptr_next;
        hold_cnt_reg <= HCNT_W'(HOLDOFF);
      end else if (state_reg == HOLD) begin
        hold_cnt_reg <= hold_cnt_reg - HCNT_W'(1);
      end
    end
  end

  assign ev_valid = ev_valid_reg;
  assign ev_idx   = ev_idx_reg;
  assign pending  = pending_reg;
  assign drop_cnt = drop_cnt_reg;

endmodule
